// File: rtl/lpc_host.sv
// LPC host initiator: converts single fabric requests into LPC I/O read/write cycles
// and reports completion, error SYNC or abort on a one-clock response strobe.
module lpc_host #(
    parameter int unsigned SYNC_TIMEOUT  = 8,
    parameter int unsigned LONG_WAIT_MAX = 1024,
    parameter int unsigned ABORT_CLKS    = 4
) (
    input  logic        clk_i,
    input  logic        nrst_i,
    output logic        lframe_o,
    inout  wire  [3:0]  lad_bus,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    output logic [1:0]  rsp_status_o,
    output logic [4:0]  current_state_o
);

    localparam int unsigned SW = $clog2(SYNC_TIMEOUT + 1);
    localparam int unsigned LW = $clog2(LONG_WAIT_MAX + 1);
    localparam int unsigned AW = $clog2(ABORT_CLKS + 1);

    localparam logic [1:0] STAT_OK    = 2'b00;
    localparam logic [1:0] STAT_ERR   = 2'b01;
    localparam logic [1:0] STAT_ABORT = 2'b10;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'd0,
        ST_START     = 5'd1,
        ST_CYCTYPE   = 5'd2,
        ST_ADDR1     = 5'd3,
        ST_ADDR2     = 5'd4,
        ST_ADDR3     = 5'd5,
        ST_ADDR4     = 5'd6,
        ST_WDATA1    = 5'd7,
        ST_WDATA2    = 5'd8,
        ST_TAR1      = 5'd9,
        ST_TAR2      = 5'd10,
        ST_SYNC      = 5'd11,
        ST_RDATA1    = 5'd12,
        ST_RDATA2    = 5'd13,
        ST_PTAR1     = 5'd14,
        ST_PTAR2     = 5'd15,
        ST_ABORT     = 5'd16,
        ST_ABORT_END = 5'd17
    } state_e;

    state_e          state_q, state_d;
    logic            write_q, write_d;
    logic [15:0]     addr_q, addr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [SW-1:0]   short_q, short_d, short_inc;
    logic [LW-1:0]   long_q, long_d, long_inc;
    logic [AW-1:0]   abort_q, abort_d;
    logic [7:0]      rbuf_q, rbuf_d;
    logic [1:0]      stat_q, stat_d;
    logic            lframe_q, lframe_d;
    logic            lad_oe_q, lad_oe_d;
    logic [3:0]      lad_q, lad_d;
    logic            ready_q, ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [7:0]      rsp_rdata_q, rsp_rdata_d;
    logic [1:0]      rsp_status_q, rsp_status_d;
    logic [3:0]      lad_in;

    assign lad_in    = lad_bus;
    assign short_inc = short_q + SW'(1);
    assign long_inc  = long_q + LW'(1);

    // Next-state, request capture, SYNC handling and response generation
    always_comb begin
        state_d      = state_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        short_d      = short_q;
        long_d       = long_q;
        abort_d      = abort_q;
        rbuf_d       = rbuf_q;
        stat_d       = stat_q;
        rsp_valid_d  = 1'b0;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_status_d = rsp_status_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i && ready_q) begin
                    state_d = ST_START;
                    write_d = req_write_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                end
            end
            ST_START:   state_d = ST_CYCTYPE;
            ST_CYCTYPE: state_d = ST_ADDR1;
            ST_ADDR1:   state_d = ST_ADDR2;
            ST_ADDR2:   state_d = ST_ADDR3;
            ST_ADDR3:   state_d = ST_ADDR4;
            ST_ADDR4:   state_d = write_q ? ST_WDATA1 : ST_TAR1;
            ST_WDATA1:  state_d = ST_WDATA2;
            ST_WDATA2:  state_d = ST_TAR1;
            ST_TAR1:    state_d = ST_TAR2;
            ST_TAR2: begin
                state_d = ST_SYNC;
                short_d = '0;
                long_d  = '0;
            end
            ST_SYNC: begin
                case (lad_in)
                    4'b0000: begin
                        state_d = write_q ? ST_PTAR1 : ST_RDATA1;
                        stat_d  = STAT_OK;
                    end
                    4'b1010: begin
                        state_d = write_q ? ST_PTAR1 : ST_RDATA1;
                        stat_d  = STAT_ERR;
                    end
                    4'b0110: begin
                        long_d  = long_inc;
                        short_d = '0;
                        if (long_inc == LW'(LONG_WAIT_MAX)) begin
                            state_d = ST_ABORT;
                            abort_d = '0;
                        end
                    end
                    // no response, short wait and undefined codes share one timeout
                    default: begin
                        short_d = short_inc;
                        if (short_inc == SW'(SYNC_TIMEOUT)) begin
                            state_d = ST_ABORT;
                            abort_d = '0;
                        end
                    end
                endcase
            end
            ST_RDATA1: begin
                state_d     = ST_RDATA2;
                rbuf_d[3:0] = lad_in;
            end
            ST_RDATA2: begin
                state_d     = ST_PTAR1;
                rbuf_d[7:4] = lad_in;
            end
            ST_PTAR1: state_d = ST_PTAR2;
            ST_PTAR2: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = write_q ? 8'h00 : rbuf_q;
                rsp_status_d = stat_q;
            end
            ST_ABORT: begin
                if (abort_q == AW'(ABORT_CLKS - 1)) begin
                    state_d = ST_ABORT_END;
                end else begin
                    abort_d = abort_q + AW'(1);
                end
            end
            ST_ABORT_END: begin
                state_d      = ST_IDLE;
                rsp_valid_d  = 1'b1;
                rsp_rdata_d  = 8'h00;
                rsp_status_d = STAT_ABORT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Bus drive for the state being entered, so pins are registered with the state
    always_comb begin
        lframe_d = 1'b1;
        lad_oe_d = 1'b1;
        lad_d    = 4'h0;
        case (state_d)
            ST_START:   lframe_d = 1'b0;
            ST_CYCTYPE: lad_d = {2'b00, write_q, 1'b0};
            ST_ADDR1:   lad_d = addr_q[15:12];
            ST_ADDR2:   lad_d = addr_q[11:8];
            ST_ADDR3:   lad_d = addr_q[7:4];
            ST_ADDR4:   lad_d = addr_q[3:0];
            ST_WDATA1:  lad_d = wdata_q[3:0];
            ST_WDATA2:  lad_d = wdata_q[7:4];
            ST_TAR1:    lad_d = 4'hF;
            ST_ABORT: begin
                lframe_d = 1'b0;
                lad_d    = 4'hF;
            end
            default:    lad_oe_d = 1'b0;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            state_q      <= ST_IDLE;
            write_q      <= 1'b0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            short_q      <= '0;
            long_q       <= '0;
            abort_q      <= '0;
            rbuf_q       <= 8'h00;
            stat_q       <= STAT_OK;
            lframe_q     <= 1'b1;
            lad_oe_q     <= 1'b0;
            lad_q        <= 4'h0;
            ready_q      <= 1'b1;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 8'h00;
            rsp_status_q <= STAT_OK;
        end else begin
            state_q      <= state_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            short_q      <= short_d;
            long_q       <= long_d;
            abort_q      <= abort_d;
            rbuf_q       <= rbuf_d;
            stat_q       <= stat_d;
            lframe_q     <= lframe_d;
            lad_oe_q     <= lad_oe_d;
            lad_q        <= lad_d;
            ready_q      <= ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign lad_bus         = lad_oe_q ? lad_q : 4'bzzzz;
    assign lframe_o        = lframe_q;
    assign req_ready_o     = ready_q;
    assign rsp_valid_o     = rsp_valid_q;
    assign rsp_rdata_o     = rsp_rdata_q;
    assign rsp_status_o    = rsp_status_q;
    assign current_state_o = state_q;

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: scripted LPC peripheral responder plus a scoreboard monitor
// that checks host LAD beats, abort drive, response latency, data and status.
module tb_lpc_host;

    localparam int ABORT_CLKS = 4;

    logic        clk_i;
    logic        nrst_i;
    logic        lframe_o;
    wire  [3:0]  lad_bus;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_write_i;
    logic [15:0] req_addr_i;
    logic [7:0]  req_wdata_i;
    logic        rsp_valid_o;
    logic [7:0]  rsp_rdata_o;
    logic [1:0]  rsp_status_o;
    logic [4:0]  current_state_o;

    lpc_host #(.SYNC_TIMEOUT(8), .LONG_WAIT_MAX(1024), .ABORT_CLKS(ABORT_CLKS)) dut (
        .clk_i          (clk_i),
        .nrst_i         (nrst_i),
        .lframe_o       (lframe_o),
        .lad_bus        (lad_bus),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_write_i    (req_write_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_status_o   (rsp_status_o),
        .current_state_o(current_state_o)
    );

    typedef struct {
        logic            chk_beats;
        int              nbeats;
        logic [8:0][4:0] beats;      // {lframe, lad} for each host-driven clock
        logic            exp_rsp;
        int              lat;        // clocks from acceptance clock to rsp_valid clock
        logic [7:0]      rdata;
        logic [1:0]      status;
        int              abort_at;   // offset of first ABORT clock, 0 = none
        logic            b2b;
    } txn_t;

    typedef struct {
        logic             write;
        int               nsync;
        logic [31:0][3:0] syncs;
        logic             has_data;
        logic [7:0]       rdata;
    } scr_t;

    txn_t txn_q[$];
    scr_t scr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0;
    int last_rsp_cyc = 0;

    logic       r_oe  = 1'b0;
    logic [3:0] r_lad = 4'h0;
    assign lad_bus = r_oe ? r_lad : 4'bzzzz;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial forever begin
        @(posedge clk_i);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic txn_t mk_txn(input int lat, input logic [7:0] rd, input logic [1:0] st);
        txn_t t;
        t.chk_beats = 1'b0;
        t.nbeats    = 0;
        t.beats     = '0;
        t.exp_rsp   = 1'b1;
        t.lat       = lat;
        t.rdata     = rd;
        t.status    = st;
        t.abort_at  = 0;
        t.b2b       = 1'b0;
        return t;
    endfunction

    function automatic scr_t mk_scr(input logic w, input int n, input logic [3:0] v,
                                    input logic [3:0] last, input logic hd, input logic [7:0] rd);
        scr_t s;
        s.write    = w;
        s.nsync    = n;
        s.syncs    = '0;
        for (int i = 0; i < n; i++) s.syncs[i] = (i == n - 1) ? last : v;
        s.has_data = hd;
        s.rdata    = rd;
        return s;
    endfunction

    // Peripheral model: counts clocks from START, drives SYNC codes then read data
    initial begin
        logic busy;
        int   off;
        int   s;
        scr_t cs;
        busy = 1'b0;
        off  = 0;
        forever begin
            @(negedge clk_i);
            if (!nrst_i) begin
                busy = 1'b0;
                r_oe = 1'b0;
            end else if (busy && rsp_valid_o) begin
                busy = 1'b0;
                r_oe = 1'b0;
            end else if (!busy && !lframe_o && scr_q.size() > 0) begin
                cs   = scr_q.pop_front();
                busy = 1'b1;
                off  = 1;
            end else if (busy) begin
                off++;
                s    = cs.write ? 11 : 9;
                r_oe = 1'b0;
                if (off >= s && off < s + cs.nsync) begin
                    r_oe  = 1'b1;
                    r_lad = cs.syncs[off - s];
                end else if (cs.has_data && off == s + cs.nsync) begin
                    r_oe  = 1'b1;
                    r_lad = cs.rdata[3:0];
                end else if (cs.has_data && off == s + cs.nsync + 1) begin
                    r_oe  = 1'b1;
                    r_lad = cs.rdata[7:4];
                end
            end
        end
    end

    // Scoreboard monitor: pops the expected transaction at START and checks it to completion
    initial begin
        logic in_txn;
        int   off;
        txn_t cur;
        in_txn = 1'b0;
        off    = 0;
        forever begin
            @(negedge clk_i);
            if (!nrst_i) begin
                in_txn = 1'b0;
            end else begin
                if (!in_txn && !lframe_o) begin
                    if (txn_q.size() == 0) begin
                        chk("unexpected_start", 32'(lframe_o), 32'd1);
                    end else begin
                        cur    = txn_q.pop_front();
                        in_txn = 1'b1;
                        off    = 0;
                        if (cur.b2b) chk("b2b_start_gap", 32'(cyc - last_rsp_cyc), 32'd1);
                    end
                end
                if (in_txn) begin
                    off++;
                    if (cur.chk_beats && off <= cur.nbeats)
                        chk("lad_beat", 32'({lframe_o, lad_bus}), 32'(cur.beats[off - 1]));
                    if (cur.abort_at != 0 && off >= cur.abort_at && off < cur.abort_at + ABORT_CLKS)
                        chk("abort_drive", 32'({lframe_o, lad_bus}), 32'h0F);
                    if (cur.abort_at != 0 && off == cur.abort_at + ABORT_CLKS)
                        chk("abort_end_lframe", 32'(lframe_o), 32'd1);
                    if (rsp_valid_o) begin
                        chk("rsp_expected", 32'(rsp_valid_o), 32'(cur.exp_rsp));
                        chk("rsp_latency", 32'(off), 32'(cur.lat));
                        chk("rsp_rdata", 32'(rsp_rdata_o), 32'(cur.rdata));
                        chk("rsp_status", 32'(rsp_status_o), 32'(cur.status));
                        chk("ready_at_rsp", 32'(req_ready_o), 32'd1);
                        in_txn       = 1'b0;
                        done_cnt++;
                        last_rsp_cyc = cyc;
                    end else begin
                        chk("ready_low_busy", 32'(req_ready_o), 32'd0);
                        if (off > cur.lat + 50) begin
                            chk("rsp_timeout", 32'(rsp_valid_o), 32'd1);
                            in_txn = 1'b0;
                            done_cnt++;
                        end
                    end
                end else begin
                    chk("no_spurious_rsp", 32'(rsp_valid_o), 32'd0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_accept();
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 200) begin
            acc = req_ready_o;
            tick();
            n++;
        end
        if (!acc) chk("accept_timeout", 32'(req_ready_o), 32'd1);
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            tick();
            n++;
        end
        if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
        tick();
    endtask

    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d,
                        input txn_t t, input scr_t s, input logic has_scr);
        txn_q.push_back(t);
        if (has_scr) scr_q.push_back(s);
        req_valid_i = 1'b1;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        wait_accept();
        req_valid_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        txn_t t2;
        scr_t s;
        scr_t s2;
        nrst_i      = 1'b0;
        req_valid_i = 1'b0;
        req_write_i = 1'b0;
        req_addr_i  = 16'h0000;
        req_wdata_i = 8'h00;
        tick();
        tick();
        chk("reset_lframe", 32'(lframe_o), 32'd1);
        chk("reset_ready", 32'(req_ready_o), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("reset_rdata", 32'(rsp_rdata_o), 32'd0);
        chk("reset_status", 32'(rsp_status_o), 32'd0);
        nrst_i = 1'b1;
        tick();

        // write 0x0080 <- 0xA5, zero-wait SYNC
        t = mk_txn(14, 8'h00, 2'b00);
        t.chk_beats = 1'b1;
        t.nbeats    = 9;
        t.beats     = {5'h1F, 5'h1A, 5'h15, 5'h10, 5'h18, 5'h10, 5'h10, 5'h12, 5'h00};
        send(1'b1, 16'h0080, 8'hA5, t, mk_scr(1'b1, 1, 4'h0, 4'h0, 1'b0, 8'h00), 1'b1);
        wait_done(1);

        // read 0x002E, two short waits, data 0x3C
        t = mk_txn(16, 8'h3C, 2'b00);
        t.chk_beats = 1'b1;
        t.nbeats    = 7;
        t.beats     = {5'h00, 5'h00, 5'h1F, 5'h1E, 5'h12, 5'h10, 5'h10, 5'h10, 5'h00};
        send(1'b0, 16'h002E, 8'h00, t, mk_scr(1'b0, 3, 4'h5, 4'h0, 1'b1, 8'h3C), 1'b1);
        wait_done(2);

        // read with no responder: eight 1111 SYNC clocks then abort
        t = mk_txn(22, 8'h00, 2'b10);
        t.abort_at = 17;
        send(1'b0, 16'h0060, 8'h00, t, mk_scr(1'b0, 8, 4'hF, 4'hF, 1'b0, 8'h00), 1'b1);
        wait_done(3);

        // zero-wait read to load rsp_rdata_o, then error-SYNC write must return 0 data
        send(1'b0, 16'h0061, 8'h00, mk_txn(14, 8'h96, 2'b00), mk_scr(1'b0, 1, 4'h0, 4'h0, 1'b1, 8'h96), 1'b1);
        wait_done(4);
        send(1'b1, 16'h0081, 8'h5A, mk_txn(14, 8'h00, 2'b01), mk_scr(1'b1, 1, 4'hA, 4'hA, 1'b0, 8'h00), 1'b1);
        wait_done(5);

        // error-SYNC read still captures data
        send(1'b0, 16'h0062, 8'h00, mk_txn(14, 8'hC3, 2'b01), mk_scr(1'b0, 1, 4'hA, 4'hA, 1'b1, 8'hC3), 1'b1);
        wait_done(6);

        // twenty long waits then ready: no abort
        send(1'b1, 16'h0082, 8'h33, mk_txn(34, 8'h00, 2'b00), mk_scr(1'b1, 21, 4'h6, 4'h0, 1'b0, 8'h00), 1'b1);
        wait_done(7);

        // two requests held valid back-to-back
        t  = mk_txn(14, 8'h00, 2'b00);
        t2 = mk_txn(14, 8'h00, 2'b00);
        t2.b2b = 1'b1;
        s  = mk_scr(1'b1, 1, 4'h0, 4'h0, 1'b0, 8'h00);
        s2 = mk_scr(1'b1, 1, 4'h0, 4'h0, 1'b0, 8'h00);
        txn_q.push_back(t);
        txn_q.push_back(t2);
        scr_q.push_back(s);
        scr_q.push_back(s2);
        req_valid_i = 1'b1;
        req_write_i = 1'b1;
        req_addr_i  = 16'h0090;
        req_wdata_i = 8'h11;
        wait_accept();
        req_addr_i  = 16'h0091;
        req_wdata_i = 8'h22;
        wait_accept();
        req_valid_i = 1'b0;
        wait_done(9);

        // reset pulse during ADDR3 discards the cycle silently
        t = mk_txn(100, 8'h00, 2'b00);
        t.exp_rsp = 1'b0;
        send(1'b1, 16'h1234, 8'h77, t, s, 1'b0);
        tick();
        tick();
        tick();
        tick();
        nrst_i = 1'b0;
        tick();
        nrst_i = 1'b1;
        chk("midreset_lframe", 32'(lframe_o), 32'd1);
        chk("midreset_ready", 32'(req_ready_o), 32'd1);
        chk("midreset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        for (int i = 0; i < 5; i++) tick();

        // subsequent read completes normally
        t = mk_txn(14, 8'h5A, 2'b00);
        t.chk_beats = 1'b1;
        t.nbeats    = 7;
        t.beats     = {5'h00, 5'h00, 5'h1F, 5'h12, 5'h10, 5'h10, 5'h10, 5'h10, 5'h00};
        send(1'b0, 16'h0002, 8'h00, t, mk_scr(1'b0, 1, 4'h0, 4'h0, 1'b1, 8'h5A), 1'b1);
        wait_done(10);
        chk("queues_drained", 32'(txn_q.size() + scr_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
